mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single SPI flash read engine (mem_read) between two requesters: instruction fetch (IF) and load unit (LS).
- Arbitrates between pending requests and sequences the start_fetch/fetch_done handshake.
- Converts the serial big-endian capture into RISC-V little-endian data, with byte/half/word extraction and sign extension for loads.
- Provides a watchdog timeout so a hung transfer returns an error instead of stalling the core.

Parameters:
- TIMEOUT_CYCLES, 4095: clk cycles allowed in WAIT before abort; must exceed the worst-case mem_read transfer of about 1050 clk.
- TO_W, 12: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  IF request, level; hold until if_ack
- if_addr  in  24  IF byte address
- if_ack  out  1  one-cycle pulse; if_rdata/if_err valid this cycle
- if_rdata  out  32  little-endian instruction word
- if_err  out  1  timeout error, valid with if_ack
- ls_req  in  1  LS request, level; hold until ls_ack
- ls_addr  in  24  LS byte address; misaligned allowed
- ls_size  in  2  0=byte, 1=half, 2=word, 3=word
- ls_signed  in  1  1=sign-extend byte/half, 0=zero-extend
- ls_ack  out  1  one-cycle pulse
- ls_rdata  out  32  extended load data
- ls_err  out  1  timeout error, valid with ls_ack
- mem_start_fetch  out  1  to mem_read start_fetch
- mem_target_address  out  24  to mem_read target_address
- mem_fetched_data  in  32  from mem_read; first received byte in [31:24]
- mem_fetch_done  in  1  from mem_read
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset:
  - State goes to IDLE; all outputs are 0; last_grant=IF; timeout counter=0.
  - Reset mid-transfer drops mem_start_fetch the same edge, so mem_read returns to its start state.
- States:
  - IDLE: if any req is high, latch the winner's address, size, signed and owner; go to WAIT. Otherwise stay.
  - WAIT: mem_start_fetch=1 and mem_target_address=latched address. The timeout counter increments each cycle.
    - On mem_fetch_done=1: capture mem_fetched_data; go to RESP with err=0.
    - Else, when the counter reaches TIMEOUT_CYCLES: go to RESP with err=1 and captured data 0.
  - RESP: mem_start_fetch=0; pulse the owner's ack with rdata/err; clear the counter; go to IDLE.
- Handshake timing:
  - mem_start_fetch deasserts for at least the RESP cycle between transfers.
  - Request sampled in IDLE at cycle N → mem_start_fetch high from N+1 → ack at the cycle after mem_fetch_done is seen.
- Arbitration (round-robin, evaluated in IDLE only):
  - One requester pending: grant it.
  - Both pending: grant the one not equal to last_grant. After reset LS wins the first tie.
  - last_grant updates on each grant.
- Request rules:
  - A req still high in IDLE after its ack is a new request (back-to-back permitted).
  - Requests arriving during WAIT/RESP wait until IDLE.
  - Address/size changes after grant are ignored.
- Byte order:
  - b0=fetched[31:24], b1=[23:16], b2=[15:8], b3=[7:0]; b0 is the byte at the request address.
  - Word = {b3,b2,b1,b0}.
  - if_rdata is always the word.
- Load extraction:
  - size 0: {24{ext}, b0}, where ext = ls_signed & b0[7].
  - size 1: {16{ext}, b1, b0}, where ext = ls_signed & b1[7].
  - size 2 or 3: word.
- Output gating: rdata outputs are 0 whenever their ack is 0. Acks are never high for both ports in the same cycle.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE, WAIT, RESP), owner encoding (OWN_IF, OWN_LS), size codes (SZ_B, SZ_H, SZ_W).
- One combinational sub-module, mem_load_align: inputs raw 32-bit capture, size, signed; outputs byte-swapped extended data. IF uses it with size=SZ_W.

Test Plan:
- Single IF: if_req=1, if_addr=0x000100; model returns fetched=0x13050000 → mem_target_address=0x000100 during WAIT; if_ack pulse with if_rdata=0x00000513, if_err=0; busy drops in the cycle after RESP.
- Signed byte: ls_size=0, ls_signed=1, fetched=0x80FFFFFF → ls_rdata=0xFFFFFF80. Same request with ls_signed=0 → 0x00000080.
- Half load: ls_size=1, ls_signed=1, fetched=0x3480AAAA → ls_rdata=0xFFFF8034. Word load of the same capture → 0xAAAA8034.
- Contention: if_req and ls_req rise in the same cycle and stay high → grants LS, IF, LS, IF. mem_start_fetch is low for ≥1 cycle between transfers.
- Timeout: IF request, model never asserts done → if_ack with if_err=1 and if_rdata=0 exactly TIMEOUT_CYCLES+2 cycles after grant; next request proceeds normally.
- Reset mid-WAIT: rst_n=0 for 1 cycle → mem_start_fetch=0, acks=0, busy=0 next cycle; a pending req is re-served from IDLE afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the flash read arbiter: FSM states, requester ids and load size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_load_align.sv
// Reorders the big-endian serial capture into a little-endian word and
// extracts/extends byte and half loads.
module mem_load_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_b0;
  logic [7:0]  w_b1;
  logic [7:0]  w_b2;
  logic [7:0]  w_b3;
  logic [31:0] w_word;
  logic        w_ext;

  // The first byte shifted in is the byte at the request address.
  assign w_b0   = i_raw[31:24];
  assign w_b1   = i_raw[23:16];
  assign w_b2   = i_raw[15:8];
  assign w_b3   = i_raw[7:0];
  assign w_word = {w_b3, w_b2, w_b1, w_b0};

  // Size selection with sign or zero extension of the top bit of the narrow value.
  always_comb begin
    w_ext  = 1'b0;
    o_data = w_word;
    case (i_size)
      SZ_B: begin
        w_ext  = i_signed & w_b0[7];
        o_data = {{24{w_ext}}, w_b0};
      end
      SZ_H: begin
        w_ext  = i_signed & w_b1[7];
        o_data = {{16{w_ext}}, w_b1, w_b0};
      end
      default: begin
        w_ext  = 1'b0;
        o_data = w_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the SPI flash read engine between instruction
// fetch and the load unit, with a watchdog that turns a hung transfer into an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int TO_W           = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [23:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [23:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_start_fetch,
  output logic [23:0] mem_target_address,
  input  logic [31:0] mem_fetched_data,
  input  logic        mem_fetch_done,
  output logic        busy
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  state_t            r_state;
  owner_t            r_owner;
  owner_t            r_last;
  logic [23:0]       r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [TO_W-1:0]   r_cnt;
  logic              r_start;
  logic              r_busy;
  logic              r_if_ack;
  logic [31:0]       r_if_rdata;
  logic              r_if_err;
  logic              r_ls_ack;
  logic [31:0]       r_ls_rdata;
  logic              r_ls_err;

  logic              w_grant_ls;
  logic              w_finish;
  logic              w_err;
  logic [31:0]       w_aligned;
  logic [31:0]       w_cap;

  // On a tie the requester that did not win last time is served.
  assign w_grant_ls = ls_req & (~if_req | (r_last == OWN_IF));
  assign w_finish   = mem_fetch_done | (r_cnt == TO_MAX);
  assign w_err      = ~mem_fetch_done;
  assign w_cap      = mem_fetch_done ? w_aligned : 32'd0;

  mem_load_align u_align (
    .i_raw    (mem_fetched_data),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_aligned)
  );

  // Arbitration FSM; ack/data registers default low so they only pulse in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_last     <= OWN_IF;
      r_addr     <= 24'd0;
      r_size     <= SZ_W;
      r_signed   <= 1'b0;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_if_ack   <= 1'b0;
      r_if_rdata <= 32'd0;
      r_if_err   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_ls_rdata <= 32'd0;
      r_ls_err   <= 1'b0;
    end else begin
      r_if_ack   <= 1'b0;
      r_if_rdata <= 32'd0;
      r_if_err   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_ls_rdata <= 32'd0;
      r_ls_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_req | ls_req) begin
            r_owner  <= w_grant_ls ? OWN_LS : OWN_IF;
            r_last   <= w_grant_ls ? OWN_LS : OWN_IF;
            r_addr   <= w_grant_ls ? ls_addr : if_addr;
            r_size   <= w_grant_ls ? ls_size : SZ_W;
            r_signed <= w_grant_ls & ls_signed;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (w_finish) begin
            r_start <= 1'b0;
            r_state <= RESP;
            if (r_owner == OWN_LS) begin
              r_ls_ack   <= 1'b1;
              r_ls_rdata <= w_cap;
              r_ls_err   <= w_err;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_cap;
              r_if_err   <= w_err;
            end
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        RESP: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_ack             = r_if_ack;
  assign if_rdata           = r_if_rdata;
  assign if_err             = r_if_err;
  assign ls_ack             = r_ls_ack;
  assign ls_rdata           = r_ls_rdata;
  assign ls_err             = r_ls_err;
  assign mem_start_fetch    = r_start;
  assign mem_target_address = r_addr;
  assign busy               = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected responses,
// a monitor pops and compares on every ack, and a flash model answers fetches.
module tb_mem_arbiter;

  localparam int T_CYC = 4095;
  localparam int BOUND = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [23:0] if_addr = 24'd0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req = 1'b0;
  logic [23:0] ls_addr = 24'd0;
  logic [1:0]  ls_size = 2'd0;
  logic        ls_signed = 1'b0;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_start_fetch;
  logic [23:0] mem_target_address;
  logic [31:0] mem_fetched_data = 32'd0;
  logic        mem_fetch_done = 1'b0;
  logic        busy;

  typedef struct { bit is_ls; logic [31:0] data; bit err; } exp_t;
  typedef struct { logic [23:0] addr; logic [31:0] data; } fetch_t;

  exp_t   sb_q[$];
  fetch_t fq[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  bit     m_hang = 1'b0;
  int     m_lat = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(T_CYC), .TO_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_start_fetch(mem_start_fetch), .mem_target_address(mem_target_address),
    .mem_fetched_data(mem_fetched_data), .mem_fetch_done(mem_fetch_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash model: answers four cycles after start_fetch is seen, one-cycle done pulse.
  initial begin
    fetch_t f;
    forever begin
      @(negedge clk);
      if (mem_fetch_done) begin
        mem_fetch_done = 1'b0;
        mem_fetched_data = 32'd0;
      end else if (mem_start_fetch && !m_hang) begin
        if (m_lat == 3) begin
          m_lat = 0;
          if (fq.size() == 0) begin
            check("unexpected_fetch", 32'd1, 32'd0);
          end else begin
            f = fq.pop_front();
            check("target_addr", {8'd0, mem_target_address}, {8'd0, f.addr});
            mem_fetched_data = f.data;
            mem_fetch_done = 1'b1;
          end
        end else begin
          m_lat++;
        end
      end else if (!mem_start_fetch) begin
        m_lat = 0;
      end
    end
  end

  // Monitor: compares every ack against the scoreboard and checks output gating.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("dual_ack", {31'd0, if_ack & ls_ack}, 32'd0);
      if (if_ack || ls_ack) begin
        check("start_low_in_resp", {31'd0, mem_start_fetch}, 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("ack_port", {31'd0, ls_ack}, {31'd0, e.is_ls});
          check("rdata", ls_ack ? ls_rdata : if_rdata, e.data);
          check("err", {31'd0, ls_ack ? ls_err : if_err}, {31'd0, e.err});
        end
      end
      if (!if_ack) check("if_gate", if_rdata, 32'd0);
      if (!ls_ack) check("ls_gate", ls_rdata, 32'd0);
    end
  end

  task automatic wait_ack(input bit is_ls, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < BOUND && !got; i++) begin
      @(negedge clk);
      waited++;
      if (is_ls ? ls_ack : if_ack) got = 1'b1;
    end
    if (!got) check(is_ls ? "ls_ack_timeout" : "if_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input bit is_ls, input logic [23:0] addr, input logic [1:0] size,
                       input bit sgn, input logic [31:0] fetched, input logic [31:0] exp_data,
                       input bit exp_err, input int exp_lat);
    int w;
    sb_q.push_back('{is_ls, exp_data, exp_err});
    if (!exp_err) fq.push_back('{addr, fetched});
    @(negedge clk);
    if (is_ls) begin
      ls_addr = addr; ls_size = size; ls_signed = sgn; ls_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    wait_ack(is_ls, w);
    check(is_ls ? "ls_latency" : "if_latency", w, exp_lat);
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  initial begin
    int w;
    int acks;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, mem_start_fetch}, 32'd0);
    check("rst_addr", {8'd0, mem_target_address}, 32'd0);
    check("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
    rst_n = 1'b1;

    // Single IF; busy must be low the cycle after RESP.
    issue(1'b0, 24'h000100, 2'd2, 1'b0, 32'h13050000, 32'h00000513, 1'b0, 5);
    @(negedge clk);
    check("busy_after_resp", {31'd0, busy}, 32'd0);

    // Contention: both rise together and stay high; expect LS, IF, LS, IF.
    sb_q.push_back('{1'b1, 32'h44332211, 1'b0});
    sb_q.push_back('{1'b0, 32'hD4C3B2A1, 1'b0});
    sb_q.push_back('{1'b1, 32'h88776655, 1'b0});
    sb_q.push_back('{1'b0, 32'h04030201, 1'b0});
    fq.push_back('{24'h000200, 32'h11223344});
    fq.push_back('{24'h000300, 32'hA1B2C3D4});
    fq.push_back('{24'h000200, 32'h55667788});
    fq.push_back('{24'h000300, 32'h01020304});
    ls_addr = 24'h000200; ls_size = 2'd2; ls_signed = 1'b0; if_addr = 24'h000300;
    if_req = 1'b1; ls_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 200 && acks < 4; i++) begin
      @(negedge clk);
      if (if_ack || ls_ack) acks++;
    end
    check("contention_acks", acks, 32'd4);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);

    // Load extraction.
    issue(1'b1, 24'h000011, 2'd0, 1'b1, 32'h80FFFFFF, 32'hFFFFFF80, 1'b0, 5);
    issue(1'b1, 24'h000011, 2'd0, 1'b0, 32'h80FFFFFF, 32'h00000080, 1'b0, 5);
    issue(1'b1, 24'h000013, 2'd0, 1'b1, 32'h7F000000, 32'h0000007F, 1'b0, 5);
    issue(1'b1, 24'h000021, 2'd1, 1'b1, 32'h3480AAAA, 32'hFFFF8034, 1'b0, 5);
    issue(1'b1, 24'h000021, 2'd1, 1'b0, 32'h3480AAAA, 32'h00008034, 1'b0, 5);
    issue(1'b1, 24'h000023, 2'd2, 1'b1, 32'h3480AAAA, 32'hAAAA8034, 1'b0, 5);
    issue(1'b1, 24'h000025, 2'd3, 1'b1, 32'h3480AAAA, 32'hAAAA8034, 1'b0, 5);

    // Timeout: flash never answers.
    m_hang = 1'b1;
    issue(1'b0, 24'h000400, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, T_CYC + 2);
    m_hang = 1'b0;
    issue(1'b0, 24'h000500, 2'd2, 1'b0, 32'h00000093, 32'h93000000, 1'b0, 5);

    // Reset during WAIT; the held request is served again afterwards.
    sb_q.push_back('{1'b0, 32'hEFBEADDE, 1'b0});
    fq.push_back('{24'h000600, 32'hDEADBEEF});
    @(negedge clk);
    if_addr = 24'h000600; if_req = 1'b1;
    for (int i = 0; i < 10 && !mem_start_fetch; i++) @(negedge clk);
    check("start_before_reset", {31'd0, mem_start_fetch}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_start", {31'd0, mem_start_fetch}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
    rst_n = 1'b1;
    wait_ack(1'b0, w);
    check("reserve_latency", w, 32'd5);
    if_req = 1'b0;

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    check("fq_empty", fq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
